// File: rtl/cpu_trap_ctrl.sv
// cpu_trap_ctrl: interrupt/trap sequencer.
// Takes the lowest-numbered enabled interrupt at an instruction boundary.
// It then stalls the core, pulses the register-file backup, and loads the
// vectored handler PC. On mret it pulses restore and reloads the saved PC.
// Handlers do not nest: new requests are held off until the block is back
// in IDLE.
module cpu_trap_ctrl #(
    parameter int              XLEN       = 32,
    parameter int              IRQ_NUM    = 8,
    parameter int              CAUSE_W    = 3,
    parameter logic [XLEN-1:0] VEC_BASE   = 32'h0000_0100,
    parameter int              VEC_STRIDE = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [IRQ_NUM-1:0] irq_req,
    input  logic [IRQ_NUM-1:0] irq_mask,
    input  logic               instr_boundary,
    input  logic [XLEN-1:0]    pc_cur,
    input  logic               mret,
    output logic               halt_req,
    output logic               gregs_backup,
    output logic               gregs_restore,
    output logic               pc_load,
    output logic [XLEN-1:0]    pc_load_val,
    output logic [IRQ_NUM-1:0] irq_ack,
    output logic               in_handler,
    output logic [CAUSE_W-1:0] cause
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SAVE    = 3'd1,
        VECTOR  = 3'd2,
        HANDLER = 3'd3,
        RESTORE = 3'd4,
        RETURN  = 3'd5
    } state_t;

    state_t              state;
    logic [XLEN-1:0]     epc;
    logic [IRQ_NUM-1:0]  pending;
    logic [CAUSE_W-1:0]  taken;
    logic [XLEN-1:0]     vec_addr;

    assign pending = irq_req & irq_mask;

    // Vector address of the latched cause; wraps modulo 2^XLEN.
    assign vec_addr = VEC_BASE + XLEN'(cause) * XLEN'(VEC_STRIDE);

    // Fixed priority: the lowest set index of pending wins.
    always_comb begin
        taken = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (pending[i]) begin
                taken = CAUSE_W'(i);
            end
        end
    end

    // Trap sequencer. Each output is registered and set together with the
    // state it belongs to. This keeps the outputs glitch-free and in step
    // with the state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            epc           <= '0;
            cause         <= '0;
            halt_req      <= 1'b0;
            gregs_backup  <= 1'b0;
            gregs_restore <= 1'b0;
            pc_load       <= 1'b0;
            pc_load_val   <= '0;
            irq_ack       <= '0;
            in_handler    <= 1'b0;
        end else begin
            // The single-cycle outputs default low and are raised only on
            // entry to the state that owns them.
            gregs_backup  <= 1'b0;
            gregs_restore <= 1'b0;
            pc_load       <= 1'b0;
            pc_load_val   <= '0;
            irq_ack       <= '0;
            case (state)
                IDLE: begin
                    halt_req   <= 1'b0;
                    in_handler <= 1'b0;
                    if ((pending != '0) && instr_boundary) begin
                        state        <= SAVE;
                        epc          <= pc_cur;
                        cause        <= taken;
                        halt_req     <= 1'b1;
                        gregs_backup <= 1'b1;
                    end
                end
                SAVE: begin
                    state       <= VECTOR;
                    halt_req    <= 1'b1;
                    pc_load     <= 1'b1;
                    pc_load_val <= vec_addr;
                    irq_ack     <= IRQ_NUM'(1) << cause;
                    in_handler  <= 1'b1;
                end
                VECTOR: begin
                    state      <= HANDLER;
                    halt_req   <= 1'b0;
                    in_handler <= 1'b1;
                end
                HANDLER: begin
                    // Requests are ignored here. They are seen again from IDLE.
                    if (mret) begin
                        state         <= RESTORE;
                        halt_req      <= 1'b1;
                        gregs_restore <= 1'b1;
                    end
                end
                RESTORE: begin
                    state       <= RETURN;
                    halt_req    <= 1'b1;
                    pc_load     <= 1'b1;
                    pc_load_val <= epc;
                end
                RETURN: begin
                    state      <= IDLE;
                    halt_req   <= 1'b0;
                    in_handler <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    halt_req   <= 1'b0;
                    in_handler <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_trap_ctrl.sv
// Bench for cpu_trap_ctrl.
// The directed steps walk through reset, entry, return, priority and masking,
// no-nesting, the boundary gate and reset mid-handler. A randomized phase
// follows. Every cycle, all outputs are compared against a timeline model.
// The model records the detection edge and the mret edge, and derives each
// output from the distance to those edges.
module tb_cpu_trap_ctrl;
    localparam int          XLEN    = 32;
    localparam int          IRQ_NUM = 8;
    localparam int          CAUSE_W = 3;
    localparam logic [31:0] VBASE   = 32'h0000_0100;
    localparam int          VSTRIDE = 4;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic [IRQ_NUM-1:0] irq_req = '0;
    logic [IRQ_NUM-1:0] irq_mask = '0;
    logic               instr_boundary = 1'b0;
    logic [XLEN-1:0]    pc_cur = '0;
    logic               mret = 1'b0;
    logic               halt_req, gregs_backup, gregs_restore, pc_load, in_handler;
    logic [XLEN-1:0]    pc_load_val;
    logic [IRQ_NUM-1:0] irq_ack;
    logic [CAUSE_W-1:0] cause;

    cpu_trap_ctrl #(
        .XLEN(XLEN), .IRQ_NUM(IRQ_NUM), .CAUSE_W(CAUSE_W),
        .VEC_BASE(VBASE), .VEC_STRIDE(VSTRIDE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .irq_req(irq_req), .irq_mask(irq_mask),
        .instr_boundary(instr_boundary), .pc_cur(pc_cur), .mret(mret),
        .halt_req(halt_req), .gregs_backup(gregs_backup),
        .gregs_restore(gregs_restore), .pc_load(pc_load),
        .pc_load_val(pc_load_val), .irq_ack(irq_ack),
        .in_handler(in_handler), .cause(cause)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Timeline model: k counts edges. te is the detection edge and tm is the
    // mret edge (-1 while no mret has been seen for the current trap).
    int          k = 0;
    int          te = -100;
    int          tm = -1;
    bit          m_active = 1'b0;
    logic [31:0] m_epc = '0;
    int          m_cause = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, k);
    endtask

    // Advance the model by the edge about to happen, using the current inputs.
    task automatic model_edge();
        logic [IRQ_NUM-1:0] pend;
        pend = irq_req & irq_mask;
        if (!reset_n) begin
            m_active = 1'b0; te = -100; tm = -1; m_epc = '0; m_cause = 0;
        end else if (m_active && tm >= 0 && k == tm + 2) begin
            m_active = 1'b0;                        // return completes
        end else if (!m_active && pend != '0 && instr_boundary) begin
            m_active = 1'b1; te = k; tm = -1; m_epc = pc_cur;
            m_cause = 0;
            while (!pend[m_cause]) m_cause++;
        end else if (m_active && tm < 0 && k >= te + 3 && mret) begin
            tm = k;                                 // mret seen while in the handler
        end
    endtask

    task automatic check_all();
        bit          bk, vc, rs, rt;
        logic [31:0] exp_val;
        bk = m_active && tm < 0 && k == te;
        vc = m_active && tm < 0 && k == te + 1;
        rs = m_active && tm >= 0 && k == tm;
        rt = m_active && tm >= 0 && k == tm + 1;
        exp_val = vc ? VBASE + 32'(m_cause) * 32'(VSTRIDE) : (rt ? m_epc : 32'h0);
        chk("halt_req",      64'(halt_req),      64'(bk | vc | rs | rt));
        chk("gregs_backup",  64'(gregs_backup),  64'(bk));
        chk("gregs_restore", 64'(gregs_restore), 64'(rs));
        chk("pc_load",       64'(pc_load),       64'(vc | rt));
        chk("pc_load_val",   64'(pc_load_val),   64'(exp_val));
        chk("irq_ack",       64'(irq_ack),       vc ? (64'd1 << m_cause) : 64'd0);
        chk("in_handler",    64'(in_handler),    64'(m_active && !bk));
        chk("cause",         64'(cause),         64'(m_cause));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
        k++;
    endtask

    initial begin
        // 1. Reset with every request high.
        reset_n = 1'b0; irq_req = 8'hFF; irq_mask = 8'hFF; instr_boundary = 1'b1;
        step(); step();
        chk("rst_ack", 64'(irq_ack), 64'h0);
        chk("rst_halt", 64'(halt_req), 64'h0);
        irq_req = 8'h00; reset_n = 1'b1;
        step();

        // 2. Single IRQ on line 2. The request drops right after it is latched.
        irq_req = 8'h04; pc_cur = 32'h0000_2000;
        step();
        chk("t2_backup", 64'(gregs_backup), 64'h1);
        irq_req = 8'h00;
        step();
        chk("t2_vec", 64'(pc_load_val), 64'h0000_0108);
        chk("t2_ack", 64'(irq_ack), 64'h04);
        chk("t2_cause", 64'(cause), 64'h2);
        chk("t2_inh", 64'(in_handler), 64'h1);
        step(); step(); step();
        chk("t2_nohalt", 64'(halt_req), 64'h0);

        // 3. Return.
        mret = 1'b1; step(); mret = 1'b0;
        chk("t3_restore", 64'(gregs_restore), 64'h1);
        chk("t3_nobackup", 64'(gregs_backup), 64'h0);
        step();
        chk("t3_epc", 64'(pc_load_val), 64'h0000_2000);
        step();
        chk("t3_inh", 64'(in_handler), 64'h0);

        // 4. Priority and mask: line 1 is masked, so line 3 wins.
        irq_mask = 8'hFD; irq_req = 8'h0A; pc_cur = 32'h0000_3000;
        step(); step();
        chk("t4_vec", 64'(pc_load_val), 64'h0000_010C);
        chk("t4_cause", 64'(cause), 64'h3);
        irq_req = 8'h00; step();
        mret = 1'b1; step(); mret = 1'b0; step(); step();
        irq_req = 8'h02; step(); step(); step();
        chk("t4_masked", 64'(gregs_backup | halt_req), 64'h0);

        // 5. No nesting: a request held during the handler waits for the return.
        irq_mask = 8'hFF; irq_req = 8'h04; pc_cur = 32'h0000_4000;
        step(); step(); step();
        irq_req = 8'h01; step(); step(); step();
        chk("t5_nonest", 64'(gregs_backup), 64'h0);
        mret = 1'b1; step(); mret = 1'b0;   // M
        step();                              // M+1
        step();                              // M+2 -> IDLE
        chk("t5_idle", 64'(in_handler), 64'h0);
        step();                              // M+3 re-entry
        chk("t5_reentry", 64'(gregs_backup), 64'h1);
        step();
        chk("t5_cause0", 64'(cause), 64'h0);
        irq_req = 8'h00; step(); step();

        // 6. Reset mid-handler: no restore is issued.
        reset_n = 1'b0; step();
        chk("t6_restore", 64'(gregs_restore), 64'h0);
        chk("t6_inh", 64'(in_handler), 64'h0);
        reset_n = 1'b1; step(); step();

        // Entry is gated on instr_boundary.
        irq_req = 8'h10; instr_boundary = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("bnd_wait", 64'(halt_req), 64'h0);
        instr_boundary = 1'b1; step();
        chk("bnd_take", 64'(gregs_backup), 64'h1);
        irq_req = 8'h00; step(); step(); mret = 1'b1; step(); mret = 1'b0; step(); step();

        // Randomized phase.
        for (int i = 0; i < 600; i++) begin
            irq_req        = ($urandom_range(0, 3) == 0) ? IRQ_NUM'($urandom) : '0;
            irq_mask       = IRQ_NUM'($urandom);
            instr_boundary = ($urandom_range(0, 3) != 0);
            mret           = ($urandom_range(0, 5) == 0);
            pc_cur         = $urandom;
            reset_n        = ($urandom_range(0, 149) != 0);
            step();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/cpu_trap_ctrl.md
Name: cpu_trap_ctrl

Overview:
Interrupt/trap sequencer that drives the general-register file's snapshot interface from the other side. On a taken interrupt it stalls the core, pulses the register-file backup, and redirects the PC to a vectored handler. On handler return (mret) it pulses restore and reloads the saved PC. It sits between the interrupt sources, the core's PC/fetch stage, and cpu_gregs.

Parameters:
XLEN, 32, data/PC width (matches CPU_XLEN)
IRQ_NUM, 8, number of interrupt request lines
CAUSE_W, 3, width of cause index (ceil(log2(IRQ_NUM)))
VEC_BASE, 32'h0000_0100, handler vector table base
VEC_STRIDE, 4, byte distance between vector entries

Ports:
clk  in  1  clock
reset_n  in  1  synchronous active-low reset
irq_req  in  IRQ_NUM  level-sensitive interrupt requests
irq_mask  in  IRQ_NUM  per-line enable (1 = enabled)
instr_boundary  in  1  core is between instructions; pc_cur is valid
pc_cur  in  XLEN  PC of the next instruction to execute
mret  in  1  handler-return instruction retired (1-cycle pulse)
halt_req  out  1  stall core fetch/execute
gregs_backup  out  1  to cpu_gregs backup (1-cycle pulse)
gregs_restore  out  1  to cpu_gregs restore (1-cycle pulse)
pc_load  out  1  force PC load (1-cycle pulse)
pc_load_val  out  XLEN  PC value applied when pc_load=1
irq_ack  out  IRQ_NUM  one-hot acknowledge of the taken line (1-cycle pulse)
in_handler  out  1  core is executing a handler
cause  out  CAUSE_W  index of the interrupt currently being serviced

Behaviour:
- Reset (clk edge with reset_n=0): state=IDLE, epc=0, cause=0, all outputs 0. Reset overrides every other input.
- Reset mid-handler: returns to IDLE without issuing a restore.
- Outputs are decoded from the registered state. epc and cause are registered.
- pending = irq_req & irq_mask. The taken line is the lowest set index of pending (fixed priority).
- IDLE:
  - If pending!=0 and instr_boundary=1 at edge N: latch epc<=pc_cur and cause<=taken index, then go to SAVE.
  - mret in IDLE is ignored.
- SAVE (cycle N+1): halt_req=1, gregs_backup=1. Next state is VECTOR.
- VECTOR (N+2):
  - halt_req=1, pc_load=1, irq_ack=(1<<cause).
  - pc_load_val = VEC_BASE + cause*VEC_STRIDE, computed in XLEN bits with wrap-around modulo 2^XLEN.
  - Next state is HANDLER.
- HANDLER (N+3 onward):
  - in_handler=1, halt_req=0.
  - No nesting: new or persisting requests are not taken. They stay pending (level) and are evaluated again after return.
  - mret=1 at edge M -> RESTORE.
- RESTORE (M+1): halt_req=1, gregs_restore=1, in_handler=1. Next state is RETURN.
- RETURN (M+2): halt_req=1, pc_load=1, pc_load_val=epc, in_handler=1. Next state is IDLE (M+3).
- Mutual exclusion:
  - gregs_backup and gregs_restore are never high in the same cycle.
  - Each is high for exactly one cycle per trap.
- pc_load_val=0 whenever pc_load=0.
- A request that deasserts after it is latched (between N and N+2) is still serviced and acked. Its cause does not change.
- Interrupt entry requires instr_boundary. If pending is set while instr_boundary=0, the block waits in IDLE indefinitely.
- If mret and a pending request are both present in HANDLER, mret wins. The request can be taken only from IDLE at M+3 or later.
- Latency:
  - Interrupt to handler PC load: 2 cycles after the detection edge.
  - mret to return PC load: 2 cycles.
  - Full trap round trip overhead: 4 stall cycles.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with irq_req=8'hFF -> all outputs 0, state IDLE, no ack.
2. Single IRQ: irq_mask=8'hFF, irq_req=8'h04, pc_cur=32'h0000_2000, instr_boundary=1 -> backup at N+1. At N+2: pc_load=1, pc_load_val=32'h0000_0108, irq_ack=8'h04, cause=2. in_handler=1 from N+2.
3. Return: after case 2, pulse mret -> restore at M+1 (backup=0). At M+2: pc_load=1, pc_load_val=32'h0000_2000. in_handler=0 at M+3.
4. Priority and mask: irq_req=8'h0A with irq_mask=8'hFD -> cause=3, pc_load_val=32'h0000_010C. irq_req=8'h02 only, with the same mask -> no trap.
5. No nesting: while in HANDLER raise irq_req=8'h01 and hold it -> no backup until after mret. Re-entry detected at the first boundary from M+3 with cause=0.
6. Reset mid-handler: assert reset_n=0 in HANDLER -> gregs_restore never pulses, and all outputs are 0 on the next cycle.
